// File: rtl/qos_fifo_reader_if.sv
// Bundle of the FIFO-side and egress-side signals of the QoS drain reader.
// master: the reader itself. slave: the FIFOs, QoS FSM and egress link around it.
interface qos_fifo_reader_if #(
   parameter int NUM_FIFO = 4,
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 4
);
   localparam int SEL_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

   logic                       active_in;
   logic [3:0]                 umbral_L;
   logic [3:0]                 umbral_H;
   logic [NUM_FIFO-1:0]        fifo_empty;
   logic [NUM_FIFO*CNT_W-1:0]  fifo_count;
   logic [NUM_FIFO*DATA_W-1:0] fifo_data;
   logic [NUM_FIFO-1:0]        pop;
   logic [NUM_FIFO-1:0]        pause;
   logic [DATA_W-1:0]          data_out;
   logic                       valid_out;
   logic [SEL_W-1:0]           sel_out;
   logic                       ready_in;

   modport master (
      input  active_in, umbral_L, umbral_H, fifo_empty, fifo_count, fifo_data, ready_in,
      output pop, pause, data_out, valid_out, sel_out
   );

   modport slave (
      output active_in, umbral_L, umbral_H, fifo_empty, fifo_count, fifo_data, ready_in,
      input  pop, pause, data_out, valid_out, sel_out
   );
endinterface

// File: rtl/qos_fifo_reader.sv
// QoS drain reader: pops one class FIFO at a time (urgent-first round robin),
// captures the word one cycle later and holds it on a valid/ready output.
// Also drives per-FIFO pause backpressure with L/H hysteresis.
module qos_fifo_reader #(
   parameter int NUM_FIFO = 4,
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 4
) (
   input logic               clk,
   input logic               reset,
   qos_fifo_reader_if.master bus
);
   localparam int SEL_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

   typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPTURE, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    grant_q, grant_d;
   logic [SEL_W-1:0]    rr_q, rr_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic [NUM_FIFO-1:0] pause_q, pause_d;
   logic [NUM_FIFO-1:0] pop_c;
   logic [NUM_FIFO-1:0] eligible, urgent, req;
   logic [SEL_W-1:0]    arb_idx;
   logic                start;

   // First requester found searching upward from ptr+1, wrapping.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_FIFO-1:0] r,
                                                input logic [SEL_W-1:0]    ptr);
      logic [SEL_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_FIFO; k++) begin
         idx = (int'(ptr) + k) % NUM_FIFO;
         if (!found && r[idx]) begin
            found = 1'b1;
            pick  = SEL_W'(idx);
         end
      end
      return pick;
   endfunction

   // Paused FIFOs that still hold data pre-empt everything else.
   assign eligible = ~bus.fifo_empty;
   assign urgent   = eligible & pause_q;
   assign req      = (|urgent) ? urgent : eligible;
   assign arb_idx  = rr_pick(req, rr_q);
   assign start    = bus.active_in && (|eligible);

   // Pause hysteresis: set at/above H (wins), release at/below L, else hold.
   always_comb begin
      pause_d = pause_q;
      for (int i = 0; i < NUM_FIFO; i++) begin
         if (bus.fifo_count[i*CNT_W +: CNT_W] >= CNT_W'(bus.umbral_H))
            pause_d[i] = 1'b1;
         else if (bus.fifo_count[i*CNT_W +: CNT_W] <= CNT_W'(bus.umbral_L))
            pause_d[i] = 1'b0;
      end
   end

   // Transfer sequencing: grant -> pop -> capture -> hold until accepted.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      valid_d = valid_q;
      pop_c   = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_POP;
               grant_d = arb_idx;
               rr_d    = arb_idx;
            end
         end
         S_POP: begin
            pop_c[grant_q] = 1'b1;
            state_d        = S_CAPTURE;
         end
         S_CAPTURE: begin
            data_d  = bus.fifo_data[int'(grant_q)*DATA_W +: DATA_W];
            sel_d   = grant_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (bus.ready_in) begin
               valid_d = 1'b0;
               if (start) begin
                  state_d = S_POP;
                  grant_d = arb_idx;
                  rr_d    = arb_idx;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         rr_q    <= SEL_W'(NUM_FIFO - 1);
         sel_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         pause_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pause_q <= pause_d;
      end
   end

   assign bus.pop       = pop_c;
   assign bus.pause     = pause_q;
   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.sel_out   = sel_q;
endmodule
